// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, special instruction
// encodings and the IF/ID pipeline-register layout. Consumed by fetch,
// decode, hazard unit and the CPU top.
package cpu_pkg;

    localparam int unsigned      PC_W        = 16;
    localparam int unsigned      INSTR_W     = 16;
    localparam logic [PC_W-1:0]  INSTR_BYTES = 16'd2;
    localparam logic [PC_W-1:0]  RESET_PC    = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

    // What the fetch stage does on a given edge, highest priority first
    // (reset is handled separately in the flops).
    typedef enum logic [1:0] {
        FETCH_REDIRECT,
        FETCH_STALL,
        FETCH_HALT,
        FETCH_RUN
    } fetch_action_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_next;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program-counter register.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (loads RESET_PC)
//   hold_i     - keep current PC
//   load_i     - load load_pc_i (wins over hold and increment)
//   load_pc_i  - parallel-load value
//   pc_o       - current PC (registered)
// Otherwise PC advances by INSTR_BYTES, wrapping modulo 2^PC_W.
module pc_register
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_pc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q + INSTR_BYTES;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and captures the returned word into the IF/ID register.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_addr       - instruction address (straight from the PC flop)
//   imem_rdata      - instruction at imem_addr, same cycle
//   stall           - hold PC and IF/ID
//   flush           - replace IF/ID contents with a bubble
//   redirect        - taken branch/jump: load redirect_pc
//   redirect_pc     - redirect target
//   if_id_instr     - latched instruction
//   if_id_pc        - address of latched instruction
//   if_id_pc_next   - if_id_pc + INSTR_BYTES (registered)
//   if_id_valid     - latched instruction is real
//   halted          - HALT captured, fetch frozen until redirect
//   fetch_count     - valid instructions latched so far (wraps)
module fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_next,
    output logic               if_id_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_action_e   action;
    logic [PC_W-1:0] pc;
    logic            halt_capture;
    logic            pc_hold;

    if_id_t      if_id_q, if_id_d;
    logic        halted_q, halted_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        if (redirect) begin
            action = FETCH_REDIRECT;
        end else if (stall) begin
            action = FETCH_STALL;
        end else if (halted_q) begin
            action = FETCH_HALT;
        end else begin
            action = FETCH_RUN;
        end
    end

    // A flushed HALT is discarded like any other word, so it neither
    // halts nor holds the PC.
    assign halt_capture = (action == FETCH_RUN) && !flush && (imem_rdata == HALT_INSTR);
    assign pc_hold      = (action == FETCH_STALL) || (action == FETCH_HALT) || halt_capture;

    pc_register u_pc (
        .clk       (clk),
        .rst       (rst),
        .hold_i    (pc_hold),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .pc_o      (pc)
    );

    // Bubbles only clear instr/valid; the PC fields keep their old values.
    always_comb begin
        if_id_d       = if_id_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;
        unique case (action)
            FETCH_REDIRECT: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
                halted_d      = 1'b0;
            end
            FETCH_STALL: begin
                if (flush) begin
                    if_id_d.instr = NOP_INSTR;
                    if_id_d.valid = 1'b0;
                end
            end
            FETCH_HALT: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
            end
            FETCH_RUN: begin
                if (flush) begin
                    if_id_d.instr = NOP_INSTR;
                    if_id_d.valid = 1'b0;
                end else begin
                    if_id_d.instr   = imem_rdata;
                    if_id_d.pc      = pc;
                    if_id_d.pc_next = pc + INSTR_BYTES;
                    if_id_d.valid   = 1'b1;
                    fetch_count_d   = fetch_count_q + 16'd1;
                    if (halt_capture) begin
                        halted_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q.instr   <= NOP_INSTR;
            if_id_q.pc      <= '0;
            if_id_q.pc_next <= '0;
            if_id_q.valid   <= 1'b0;
            halted_q        <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            if_id_q       <= if_id_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr     = pc;
    assign if_id_instr   = if_id_q.instr;
    assign if_id_pc      = if_id_q.pc;
    assign if_id_pc_next = if_id_q.pc_next;
    assign if_id_valid   = if_id_q.valid;
    assign halted        = halted_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns 16'h1000+addr,
// except 0x000C returns HALT once halt_en is set.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall, flush, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc_next;
    logic        if_id_valid, halted;
    logic [15:0] fetch_count;
    logic        halt_en;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (halt_en && imem_addr == 16'h000C) begin
            imem_rdata = 16'hFFFF;
        end else begin
            imem_rdata = 16'h1000 + imem_addr;
        end
    end

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_next (if_id_pc_next),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the IF/ID view plus address and count in one go.
    task automatic chk_ifid(input string tag, input logic [15:0] addr, input logic [15:0] pc,
                            input logic [15:0] instr, input logic valid, input logic [15:0] cnt);
        chk({tag, ".addr"},  32'(imem_addr),   32'(addr));
        chk({tag, ".pc"},    32'(if_id_pc),    32'(pc));
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
        chk({tag, ".cnt"},   32'(fetch_count), 32'(cnt));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"},   32'(imem_addr),     32'h0);
        chk({tag, ".instr"},  32'(if_id_instr),   32'h0);
        chk({tag, ".pc"},     32'(if_id_pc),      32'h0);
        chk({tag, ".pcnext"}, 32'(if_id_pc_next), 32'h0);
        chk({tag, ".valid"},  32'(if_id_valid),   32'h0);
        chk({tag, ".halted"}, 32'(halted),        32'h0);
        chk({tag, ".cnt"},    32'(fetch_count),   32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; halt_en = 1'b0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;

        // Sequential fetch
        tick(); chk_ifid("seq0", 16'h0002, 16'h0000, 16'h1000, 1'b1, 16'd1);
        chk("seq0.pcnext", 32'(if_id_pc_next), 32'h0002);
        tick(); chk_ifid("seq1", 16'h0004, 16'h0002, 16'h1002, 1'b1, 16'd2);
        tick(); chk_ifid("seq2", 16'h0006, 16'h0004, 16'h1004, 1'b1, 16'd3);

        // Stall three cycles at PC=6
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_ifid("stall", 16'h0006, 16'h0004, 16'h1004, 1'b1, 16'd3);
        end
        stall = 1'b0;
        tick(); chk_ifid("unstall", 16'h0008, 16'h0006, 16'h1006, 1'b1, 16'd4);

        // Flush alone at PC=8: word dropped, PC advances
        flush = 1'b1;
        tick(); chk_ifid("flush", 16'h000A, 16'h0006, 16'h0000, 1'b0, 16'd4);
        flush = 1'b0;
        tick(); chk_ifid("postflush", 16'h000C, 16'h000A, 16'h100A, 1'b1, 16'd5);

        // HALT at 0x0C
        halt_en = 1'b1;
        tick(); chk_ifid("halt", 16'h000C, 16'h000C, 16'hFFFF, 1'b1, 16'd6);
        chk("halt.halted", 32'(halted), 32'h1);
        chk("halt.pcnext", 32'(if_id_pc_next), 32'h000E);
        tick(); chk_ifid("halted1", 16'h000C, 16'h000C, 16'h0000, 1'b0, 16'd6);
        tick(); chk_ifid("halted2", 16'h000C, 16'h000C, 16'h0000, 1'b0, 16'd6);
        chk("halted2.halted", 32'(halted), 32'h1);

        // Redirect while stalled also releases halt
        redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
        tick(); chk_ifid("redir40", 16'h0040, 16'h000C, 16'h0000, 1'b0, 16'd6);
        chk("redir40.halted", 32'(halted), 32'h0);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_ifid("at40", 16'h0042, 16'h0040, 16'h1040, 1'b1, 16'd7);

        // Redirect to 0x20
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick(); chk_ifid("redir20", 16'h0020, 16'h0040, 16'h0000, 1'b0, 16'd7);
        redirect = 1'b0;
        tick(); chk_ifid("at20", 16'h0022, 16'h0020, 16'h1020, 1'b1, 16'd8);

        // Stall + flush: bubble, PC holds
        stall = 1'b1; flush = 1'b1;
        tick(); chk_ifid("stallflush", 16'h0022, 16'h0020, 16'h0000, 1'b0, 16'd8);
        stall = 1'b0; flush = 1'b0;
        tick(); chk_ifid("at22", 16'h0024, 16'h0022, 16'h1022, 1'b1, 16'd9);

        // PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(); chk_ifid("redirFFFE", 16'hFFFE, 16'h0022, 16'h0000, 1'b0, 16'd9);
        redirect = 1'b0;
        tick(); chk_ifid("atFFFE", 16'h0000, 16'hFFFE, 16'h0FFE, 1'b1, 16'd10);
        chk("atFFFE.pcnext", 32'(if_id_pc_next), 32'h0000);
        tick(); chk_ifid("at0000", 16'h0002, 16'h0000, 16'h1000, 1'b1, 16'd11);

        // Redirect beats flush, then reset while stalled at 0x30
        redirect = 1'b1; redirect_pc = 16'h0030; flush = 1'b1;
        tick(); chk_ifid("redirflush", 16'h0030, 16'h0000, 16'h0000, 1'b0, 16'd11);
        redirect = 1'b0; flush = 1'b0; stall = 1'b1;
        tick(); chk_ifid("stall30", 16'h0030, 16'h0000, 16'h0000, 1'b0, 16'd11);
        rst = 1'b1;
        tick(); chk_reset("midreset");
        rst = 1'b0; stall = 1'b0;
        tick(); chk_ifid("afterreset", 16'h0002, 16'h0000, 16'h1000, 1'b1, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
